// File: rtl/fifo_reader_if.sv
// Handshake bundle for fifo_reader: FIFO read port on one side, packed-word stream on the other.
// The master modport is the reader; the slave modport is the FIFO plus downstream sink.
interface fifo_reader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4
);
    logic                      fifo_empty;
    logic                      fifo_r_en;
    logic [DATA_W-1:0]         fifo_rdata;
    logic                      m_valid;
    logic [DATA_W*LANES-1:0]   m_data;
    logic [LANES-1:0]          m_keep;
    logic                      m_ready;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_r_en, m_valid, m_data, m_keep
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_r_en, m_valid, m_data, m_keep
    );
endinterface

// File: rtl/fifo_reader.sv
// Pulls bytes from a FIFO read port and packs them LANES at a time into a one-slot output word.
// A partial word is flushed with a lane mask after TIMEOUT idle cycles.
module fifo_reader #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_reader_if.master bus_io
);
    localparam int unsigned CntW  = $clog2(LANES + 1);
    localparam int unsigned WordW = DATA_W * LANES;

    typedef enum logic [1:0] {StEmpty, StFill, StHold, StFlush} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             rd_pend_q;
    logic [7:0]       idle_q, idle_d;
    logic [WordW-1:0] asm_q, asm_d;
    logic             m_valid_q, m_valid_d;
    logic [WordW-1:0] m_data_q, m_data_d;
    logic [LANES-1:0] m_keep_q, m_keep_d;
    logic             rd_en;
    logic             slot_free;

    // rd_en already includes ~fifo_empty, so it doubles as "read accepted this edge".
    assign rd_en = ~bus_io.fifo_empty
                 & ((32'(cnt_q) + 32'(rd_pend_q)) < LANES)
                 & (32'(idle_q) != TIMEOUT)
                 & rst_n;

    assign slot_free = ~m_valid_q | bus_io.m_ready;

    always_comb begin
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        m_valid_d = m_valid_q & ~bus_io.m_ready;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;

        if (rd_pend_q) begin
            asm_d[32'(cnt_q) * DATA_W +: DATA_W] = bus_io.fifo_rdata;
            cnt_d = cnt_q + 1'b1;
            if (32'(cnt_q) == LANES - 1 && slot_free) begin
                m_valid_d = 1'b1;
                m_data_d  = asm_d;
                m_keep_d  = '1;
                cnt_d     = '0;
            end
        end

        unique case (state_q)
            StHold: begin
                if (slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = asm_q;
                    m_keep_d  = '1;
                    cnt_d     = '0;
                end
            end
            StFlush: begin
                if (slot_free) begin
                    m_valid_d = 1'b1;
                    cnt_d     = '0;
                    for (int i = 0; i < int'(LANES); i++) begin
                        m_keep_d[i] = (i < int'(cnt_q));
                        m_data_d[i*DATA_W +: DATA_W] =
                            m_keep_d[i] ? asm_q[i*DATA_W +: DATA_W] : '0;
                    end
                end
            end
            default: ;
        endcase

        if (rd_en || rd_pend_q || cnt_q == '0 || (state_q == StFlush && slot_free)) begin
            idle_d = '0;
        end else if (32'(cnt_q) < LANES && 32'(idle_q) < TIMEOUT) begin
            idle_d = idle_q + 8'd1;
        end

        if (cnt_d == '0) begin
            state_d = StEmpty;
        end else if (32'(cnt_d) == LANES) begin
            state_d = StHold;
        end else if (32'(idle_d) == TIMEOUT) begin
            state_d = StFlush;
        end else begin
            state_d = StFill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            idle_q    <= '0;
            asm_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_en;
            idle_q    <= idle_d;
            asm_q     <= asm_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
        end
    end

    assign bus_io.fifo_r_en = rd_en;
    assign bus_io.m_valid   = m_valid_q;
    assign bus_io.m_data    = m_data_q;
    assign bus_io.m_keep    = m_keep_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-backed FIFO model feeds bytes, a monitor logs accepted beats,
// and each scenario task compares the beats against words built from the byte stream.
module tb_fifo_reader;
    localparam int Lanes   = 4;
    localparam int Timeout = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_W(8), .LANES(Lanes)) bus ();

    fifo_reader #(.DATA_W(8), .LANES(Lanes), .TIMEOUT(Timeout)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    typedef struct { logic [7:0] data; int gap; } src_t;
    typedef struct { logic [31:0] data; logic [3:0] keep; int cyc; } beat_t;

    src_t  src_q[$];
    beat_t beat_q[$];
    int    cyc      = 0;
    int    nreads   = 0;
    int    last_acc = 0;
    int    gap_cnt  = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    // FIFO model and beat monitor share one process so both see the same cycle number.
    initial begin
        bit acc;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        forever begin
            @(posedge clk);
            cyc++;
            acc = bus.fifo_r_en && !bus.fifo_empty;
            if (bus.m_valid && bus.m_ready)
                beat_q.push_back('{data: bus.m_data, keep: bus.m_keep, cyc: cyc});
            #1;
            if (acc) begin
                bus.fifo_rdata = src_q[0].data;
                src_q.delete(0);
                nreads++;
                last_acc = cyc;
                gap_cnt = (src_q.size() != 0) ? src_q[0].gap : 0;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            bus.fifo_empty = (src_q.size() == 0) || (gap_cnt > 0);
        end
    end

    task automatic push_byte(input logic [7:0] d, input int gap);
        if (src_q.size() == 0) gap_cnt = gap;
        src_q.push_back('{data: d, gap: gap});
    endtask

    task automatic wait_reads(input int n, output bit ok);
        int t = 0;
        while (nreads < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = (nreads >= n);
    endtask

    task automatic wait_beats(input int n, output bit ok);
        int t = 0;
        while (beat_q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = (beat_q.size() >= n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.m_ready = 1'b1;
        push_byte(8'h5A, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.fifo_r_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_r_en: got %b expected 0 (fifo_empty=%b)", bus.fifo_r_en,
                     bus.fifo_empty);
        end
        n_checks++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid);
        end
        n_checks++;
        if (bus.m_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_m_data: got %h expected 0", bus.m_data);
        end
        n_checks++;
        if (bus.m_keep !== 4'h0) begin
            n_fail++; $display("FAIL reset_m_keep: got %h expected 0", bus.m_keep);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_after_reset();
        bit ok;
        beat_q.delete();
        push_byte(8'h6B, 0);
        push_byte(8'h7C, 0);
        push_byte(8'h8D, 0);
        wait_beats(1, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || beat_q.size() != 1) begin
            n_fail++; $display("FAIL first_beats: got %0d beats expected 1", beat_q.size());
        end else begin
            n_checks++;
            if (beat_q[0].data !== 32'h8D7C6B5A || beat_q[0].keep !== 4'hF) begin
                n_fail++;
                $display("FAIL first_word: got %h/%h expected 8d7c6b5a/f", beat_q[0].data,
                         beat_q[0].keep);
            end
        end
    endtask

    task automatic test_full_word();
        bit ok;
        int r0 = nreads;
        beat_q.delete();
        bus.m_ready = 1'b1;
        push_byte(8'h11, 0);
        push_byte(8'h22, 0);
        push_byte(8'h33, 0);
        push_byte(8'h44, 0);
        wait_beats(1, ok);
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || beat_q.size() != 1) begin
            n_fail++; $display("FAIL full_beats: got %0d beats expected 1", beat_q.size());
        end else begin
            n_checks++;
            if (beat_q[0].data !== 32'h44332211) begin
                n_fail++;
                $display("FAIL full_data: got %h expected 44332211", beat_q[0].data);
            end
            n_checks++;
            if (beat_q[0].keep !== 4'hF) begin
                n_fail++; $display("FAIL full_keep: got %h expected f", beat_q[0].keep);
            end
        end
        n_checks++;
        if (nreads - r0 != 4) begin
            n_fail++; $display("FAIL full_reads: got %0d expected 4", nreads - r0);
        end
    endtask

    task automatic test_flush();
        bit ok;
        int a;
        int t = 0;
        int r0 = nreads;
        beat_q.delete();
        bus.m_ready = 1'b1;
        push_byte(8'hAA, 0);
        push_byte(8'hBB, 0);
        wait_reads(r0 + 2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL flush_reads: got %0d expected %0d", nreads, r0 + 2);
        end
        a = last_acc;
        // idle count hits TIMEOUT at edge a+TIMEOUT+1; make fifo_empty fall at that same edge
        while (cyc < a + Timeout && t < 200) begin
            @(negedge clk);
            t++;
        end
        push_byte(8'hD1, 0);
        @(negedge clk);
        n_checks++;
        if (bus.fifo_r_en !== 1'b0 || bus.fifo_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_r_en_at_timeout: got r_en=%b empty=%b expected r_en=0 empty=0",
                     bus.fifo_r_en, bus.fifo_empty);
        end
        push_byte(8'hD2, 0);
        push_byte(8'hD3, 0);
        push_byte(8'hD4, 0);
        wait_beats(2, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || beat_q.size() != 2) begin
            n_fail++; $display("FAIL flush_beats: got %0d beats expected 2", beat_q.size());
        end else begin
            n_checks++;
            if (beat_q[0].data !== 32'h0000BBAA || beat_q[0].keep !== 4'h3) begin
                n_fail++;
                $display("FAIL flush_word: got %h/%h expected 0000bbaa/3", beat_q[0].data,
                         beat_q[0].keep);
            end
            n_checks++;
            if (beat_q[0].cyc != a + Timeout + 3) begin
                n_fail++;
                $display("FAIL flush_timing: got cycle %0d expected %0d", beat_q[0].cyc,
                         a + Timeout + 3);
            end
            n_checks++;
            if (beat_q[1].data !== 32'hD4D3D2D1 || beat_q[1].keep !== 4'hF) begin
                n_fail++;
                $display("FAIL flush_next_word: got %h/%h expected d4d3d2d1/f", beat_q[1].data,
                         beat_q[1].keep);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable = 1'b1;
        int r0 = nreads;
        beat_q.delete();
        @(negedge clk);
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 9; i++) push_byte(8'(i), 0);
        wait_reads(r0 + 8, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || nreads - r0 != 8) begin
            n_fail++; $display("FAIL bp_reads: got %0d expected 8", nreads - r0);
        end
        n_checks++;
        if (bus.fifo_r_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold_r_en: got %b expected 0", bus.fifo_r_en);
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h04030201 || bus.m_keep !== 4'hF)
                stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_stable: got %b/%h/%h expected 1/04030201/f", bus.m_valid,
                     bus.m_data, bus.m_keep);
        end
        n_checks++;
        if (beat_q.size() != 0) begin
            n_fail++; $display("FAIL bp_no_beat: got %0d beats expected 0", beat_q.size());
        end
        bus.m_ready = 1'b1;
        push_byte(8'h0A, 0);
        push_byte(8'h0B, 0);
        push_byte(8'h0C, 0);
        wait_beats(3, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || beat_q.size() != 3) begin
            n_fail++; $display("FAIL bp_beats: got %0d beats expected 3", beat_q.size());
        end else begin
            n_checks++;
            if (beat_q[0].data !== 32'h04030201 || beat_q[1].data !== 32'h08070605) begin
                n_fail++;
                $display("FAIL bp_order: got %h,%h expected 04030201,08070605", beat_q[0].data,
                         beat_q[1].data);
            end
            n_checks++;
            if (beat_q[1].cyc != beat_q[0].cyc + 1) begin
                n_fail++;
                $display("FAIL bp_no_bubble: got gap %0d expected 1",
                         beat_q[1].cyc - beat_q[0].cyc);
            end
            n_checks++;
            if (beat_q[2].data !== 32'h0C0B0A09 || beat_q[2].keep !== 4'hF) begin
                n_fail++;
                $display("FAIL bp_third: got %h/%h expected 0c0b0a09/f", beat_q[2].data,
                         beat_q[2].keep);
            end
        end
    endtask

    task automatic test_gap();
        bit ok;
        beat_q.delete();
        bus.m_ready = 1'b1;
        push_byte(8'h31, 0);
        push_byte(8'h32, 0);
        push_byte(8'h33, 10);
        push_byte(8'h34, 0);
        wait_beats(1, ok);
        repeat (Timeout + 6) @(negedge clk);
        n_checks++;
        if (!ok || beat_q.size() != 1) begin
            n_fail++; $display("FAIL gap_beats: got %0d beats expected 1", beat_q.size());
        end else begin
            n_checks++;
            if (beat_q[0].data !== 32'h34333231 || beat_q[0].keep !== 4'hF) begin
                n_fail++;
                $display("FAIL gap_word: got %h/%h expected 34333231/f", beat_q[0].data,
                         beat_q[0].keep);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0 = nreads;
        beat_q.delete();
        bus.m_ready = 1'b1;
        push_byte(8'hE1, 0);
        push_byte(8'hE2, 0);
        wait_reads(r0 + 2, ok);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 32'h0 || bus.m_keep !== 4'h0 ||
            bus.fifo_r_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b d=%h k=%h r_en=%b expected all 0",
                     bus.m_valid, bus.m_data, bus.m_keep, bus.fifo_r_en);
        end
        rst_n = 1'b1;
        beat_q.delete();
        push_byte(8'hC1, 0);
        push_byte(8'hC2, 0);
        push_byte(8'hC3, 0);
        push_byte(8'hC4, 0);
        wait_beats(1, ok);
        repeat (Timeout + 6) @(negedge clk);
        n_checks++;
        if (!ok || beat_q.size() != 1) begin
            n_fail++; $display("FAIL midreset_beats: got %0d beats expected 1", beat_q.size());
        end else begin
            n_checks++;
            if (beat_q[0].data !== 32'hC4C3C2C1 || beat_q[0].keep !== 4'hF) begin
                n_fail++;
                $display("FAIL midreset_word: got %h/%h expected c4c3c2c1/f", beat_q[0].data,
                         beat_q[0].keep);
            end
        end
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 4; iter++) begin
            logic [7:0]  bytes[$];
            logic [31:0] ew;
            logic [3:0]  ek;
            int          n;
            int          nexp;
            int          t = 0;
            beat_q.delete();
            n = $urandom_range(22, 1);
            nexp = (n + Lanes - 1) / Lanes;
            for (int i = 0; i < n; i++) begin
                logic [7:0] d = 8'($urandom);
                bytes.push_back(d);
                push_byte(d, $urandom_range(8, 0));
            end
            while (beat_q.size() < nexp && t < 3000) begin
                @(negedge clk);
                bus.m_ready = ($urandom_range(1, 0) != 0);
                t++;
            end
            bus.m_ready = 1'b1;
            repeat (Timeout + 8) @(negedge clk);
            n_checks++;
            if (beat_q.size() != nexp) begin
                n_fail++;
                $display("FAIL rand_beats[%0d]: got %0d expected %0d", iter, beat_q.size(), nexp);
            end
            for (int w = 0; w < nexp && w < beat_q.size(); w++) begin
                ew = '0;
                ek = '0;
                for (int l = 0; l < Lanes; l++) begin
                    if (w * Lanes + l < n) begin
                        ew[l*8 +: 8] = bytes[w*Lanes+l];
                        ek[l] = 1'b1;
                    end
                end
                n_checks++;
                if (beat_q[w].data !== ew || beat_q[w].keep !== ek) begin
                    n_fail++;
                    $display("FAIL rand_word[%0d.%0d]: got %h/%h expected %h/%h", iter, w,
                             beat_q[w].data, beat_q[w].keep, ew, ek);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_first_after_reset();
        test_full_word();
        test_flush();
        test_backpressure();
        test_gap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
